// File: rtl/bk_pkg.sv
// Shared definitions for the breakdown-test pulse generators on the 25 MHz domain.
// The timing constants keep the single-channel generator and the scheduler in agreement.
package bk_pkg;

   localparam int unsigned BK_PULSE_CYC = 875;     // 35 us at 25 MHz
   localparam int unsigned BK_SLOT_CYC  = 250000;  // 10 ms at 25 MHz

   typedef enum logic [1:0] {
      BK_IDLE  = 2'd0,
      BK_PULSE = 2'd1,
      BK_GAP   = 2'd2
   } bk_state_e;

endpackage : bk_pkg

// File: rtl/bk_rr_next.sv
// Round-robin successor: the next enabled channel above cur_i, or the lowest enabled
// channel with wrap set when none is above. An empty mask returns channel 0 with wrap set.
module bk_rr_next #(
   parameter int unsigned CH_NUM = 4
) (
   input  logic [CH_NUM-1:0]         mask_i,
   input  logic [$clog2(CH_NUM)-1:0] cur_i,
   output logic [$clog2(CH_NUM)-1:0] nxt_ch_c_o,
   output logic                      wrap_c_o
);
   localparam int unsigned CH_W = $clog2(CH_NUM);

   always_comb begin
      nxt_ch_c_o = '0;
      wrap_c_o   = 1'b1;
      // Downward scan so the lowest qualifying channel is the last one written.
      for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
         if (mask_i[i] && (CH_W'(i) > cur_i)) begin
            nxt_ch_c_o = CH_W'(i);
            wrap_c_o   = 1'b0;
         end
      end
      if (wrap_c_o) begin
         for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (mask_i[i]) nxt_ch_c_o = CH_W'(i);
         end
      end
   end

endmodule : bk_rr_next

// File: rtl/bk_test_sched.sv
// Multi-channel breakdown-test pulse scheduler: one pulse per slot, round-robin over the
// latched channel mask, with sticky per-channel no-response faults.
module bk_test_sched
   import bk_pkg::*;
#(
   parameter int unsigned CH_NUM    = 4,
   parameter int unsigned PULSE_CYC = BK_PULSE_CYC,
   parameter int unsigned SLOT_CYC  = BK_SLOT_CYC,
   parameter int unsigned CNT_W     = 18
) (
   input  logic                      i_clk_25m,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_stop,
   input  logic                      i_continuous,
   input  logic [CH_NUM-1:0]         i_ch_en,
   input  logic [CH_NUM-1:0]         i_resp,
   input  logic                      i_fault_clr,
   output logic [CH_NUM-1:0]         o_bk_pulse,
   output logic [$clog2(CH_NUM)-1:0] o_cur_ch,
   output logic                      o_busy,
   output logic                      o_round_done,
   output logic [CH_NUM-1:0]         o_fault
);
   localparam int unsigned CH_W      = $clog2(CH_NUM);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);

   bk_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CH_NUM-1:0] mask_q, mask_d;
   logic [CH_W-1:0]   cur_q, cur_d;
   logic [CH_NUM-1:0] pulse_q, pulse_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CH_NUM-1:0] fault_q, fault_d;
   logic              seen_q, seen_d;

   logic [CH_W-1:0]   rr_nxt;
   logic              rr_wrap;
   logic [CH_W-1:0]   first_ch;
   logic              resp_cur;

   bk_rr_next #(.CH_NUM(CH_NUM)) u_rr_next (
      .mask_i     (mask_q),
      .cur_i      (cur_q),
      .nxt_ch_c_o (rr_nxt),
      .wrap_c_o   (rr_wrap)
   );

   // Lowest enabled channel of the live mask, used at every round latch.
   always_comb begin
      first_ch = '0;
      for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
         if (i_ch_en[i]) first_ch = CH_W'(i);
      end
   end

   assign resp_cur = i_resp[cur_q];

   always_ff @(posedge i_clk_25m) begin
      if (!i_rst_n) begin
         state_q <= BK_IDLE;
         cnt_q   <= '0;
         mask_q  <= '0;
         cur_q   <= '0;
         pulse_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         cur_q   <= cur_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         seen_q  <= seen_d;
      end
   end

   // Next-state and registered-output logic; a fault set is written after the clear.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      cur_d   = cur_q;
      pulse_d = pulse_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      fault_d = fault_q & ~{CH_NUM{i_fault_clr}};
      seen_d  = seen_q;

      if (i_stop) begin
         state_d = BK_IDLE;
         cnt_d   = '0;
         pulse_d = '0;
         busy_d  = 1'b0;
         seen_d  = 1'b0;
      end else begin
         unique case (state_q)
            BK_IDLE: begin
               if (i_start && (i_ch_en != '0)) begin
                  mask_d  = i_ch_en;
                  cur_d   = first_ch;
                  state_d = BK_PULSE;
                  cnt_d   = '0;
                  pulse_d = CH_NUM'(1) << first_ch;
                  busy_d  = 1'b1;
                  seen_d  = 1'b0;
               end
            end
            BK_PULSE: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (resp_cur) seen_d = 1'b1;
               if (cnt_q == PULSE_LAST) begin
                  state_d = BK_GAP;
                  pulse_d = '0;
                  if (!(seen_q || resp_cur)) fault_d[cur_q] = 1'b1;
               end
            end
            BK_GAP: begin
               if (cnt_q != SLOT_LAST) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (!rr_wrap) begin
                  cur_d   = rr_nxt;
                  state_d = BK_PULSE;
                  cnt_d   = '0;
                  pulse_d = CH_NUM'(1) << rr_nxt;
                  seen_d  = 1'b0;
               end else begin
                  done_d = 1'b1;
                  cnt_d  = '0;
                  seen_d = 1'b0;
                  if (i_continuous && (i_ch_en != '0)) begin
                     mask_d  = i_ch_en;
                     cur_d   = first_ch;
                     state_d = BK_PULSE;
                     pulse_d = CH_NUM'(1) << first_ch;
                  end else begin
                     state_d = BK_IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end
            default: begin
               state_d = BK_IDLE;
               cnt_d   = '0;
               pulse_d = '0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign o_bk_pulse   = pulse_q;
   assign o_cur_ch     = cur_q;
   assign o_busy       = busy_q;
   assign o_round_done = done_q;
   assign o_fault      = fault_q;

endmodule : bk_test_sched

// File: tb/tb_bk_test_sched.sv
// Directed bench for bk_test_sched with a short slot (PULSE_CYC=4, SLOT_CYC=10, 4 channels).
module tb_bk_test_sched;

   logic       clk;
   logic       rst_n;
   logic       start, stop, cont, clr;
   logic [3:0] ch_en;
   logic [3:0] tie;
   logic [3:0] resp;
   logic [3:0] bk_pulse;
   logic [1:0] cur_ch;
   logic       busy, round_done;
   logic [3:0] fault;

   int checks = 0;
   int errors = 0;

   // Responses follow the pulses only on channels selected by tie.
   assign resp = bk_pulse & tie;

   bk_test_sched #(
      .CH_NUM   (4),
      .PULSE_CYC(4),
      .SLOT_CYC (10),
      .CNT_W    (18)
   ) dut (
      .i_clk_25m   (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_stop      (stop),
      .i_continuous(cont),
      .i_ch_en     (ch_en),
      .i_resp      (resp),
      .i_fault_clr (clr),
      .o_bk_pulse  (bk_pulse),
      .o_cur_ch    (cur_ch),
      .o_busy      (busy),
      .o_round_done(round_done),
      .o_fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start, stop, cont, clr;
      logic [3:0] en, tie;
      int         adv;
      logic [3:0] pulse;
      logic       busy, done;
      logic [3:0] fault;
      logic [1:0] cur;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic s, logic p, logic c, logic cl, logic [3:0] en,
                              logic [3:0] t, int adv, logic [3:0] pu, logic b,
                              logic d, logic [3:0] f, logic [1:0] cu);
      vec_t r;
      r.start = s;  r.stop = p;  r.cont = c;  r.clr = cl;
      r.en = en;    r.tie = t;   r.adv = adv;
      r.pulse = pu; r.busy = b;  r.done = d;  r.fault = f; r.cur = cu;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [3:0] pu, logic b, logic d,
                          logic [3:0] f, logic [1:0] cu);
      chk({tag, " pulse"}, bk_pulse, pu);
      chk({tag, " busy"},  {3'b0, busy}, {3'b0, b});
      chk({tag, " done"},  {3'b0, round_done}, {3'b0, d});
      chk({tag, " fault"}, fault, f);
      chk({tag, " cur"},   {2'b0, cur_ch}, {2'b0, cu});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; clr = 1'b0;
      ch_en = 4'h0; tie = 4'h0;

      // start stop cont clr en tie adv | pulse busy done fault cur
      // Round over 1011 with all responses present.
      vecs.push_back(v(1,0,0,0,4'hB,4'hF,1, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,3, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,1, 4'h0,1,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,6, 4'h2,1,0,4'h0,1));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,3, 4'h2,1,0,4'h0,1));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,1, 4'h0,1,0,4'h0,1));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,6, 4'h8,1,0,4'h0,3));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,3, 4'h8,1,0,4'h0,3));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,1, 4'h0,1,0,4'h0,3));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,5, 4'h0,1,0,4'h0,3));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,1, 4'h0,0,1,4'h0,3));
      vecs.push_back(v(0,0,0,0,4'hB,4'hF,1, 4'h0,0,0,4'h0,3));
      // Mask 0110, channel 2 silent; then clear.
      vecs.push_back(v(1,0,0,0,4'h6,4'hB,1, 4'h2,1,0,4'h0,1));
      vecs.push_back(v(0,0,0,0,4'h6,4'hB,4, 4'h0,1,0,4'h0,1));
      vecs.push_back(v(0,0,0,0,4'h6,4'hB,6, 4'h4,1,0,4'h0,2));
      vecs.push_back(v(0,0,0,0,4'h6,4'hB,3, 4'h4,1,0,4'h0,2));
      vecs.push_back(v(0,0,0,0,4'h6,4'hB,1, 4'h0,1,0,4'h4,2));
      vecs.push_back(v(0,0,0,0,4'h6,4'hB,6, 4'h0,0,1,4'h4,2));
      vecs.push_back(v(0,0,0,1,4'h6,4'hB,1, 4'h0,0,0,4'h0,2));
      // Continuous on ch0, mask switched to ch1 mid-slot, then stop.
      vecs.push_back(v(1,0,1,0,4'h1,4'hF,1, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,0,1,0,4'h1,4'hF,10,4'h1,1,1,4'h0,0));
      vecs.push_back(v(0,0,1,0,4'h1,4'hF,1, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,0,1,0,4'h1,4'hF,3, 4'h0,1,0,4'h0,0));
      vecs.push_back(v(0,0,1,0,4'h2,4'hF,6, 4'h2,1,1,4'h0,1));
      vecs.push_back(v(0,0,1,0,4'h2,4'hF,10,4'h2,1,1,4'h0,1));
      vecs.push_back(v(0,1,1,0,4'h2,4'hF,1, 4'h0,0,0,4'h0,1));
      // Stop during a silent pulse, then stop beating start.
      vecs.push_back(v(1,0,0,0,4'h1,4'h0,1, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h1,4'h0,1, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,1,0,0,4'h1,4'h0,1, 4'h0,0,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h1,4'h0,12,4'h0,0,0,4'h0,0));
      vecs.push_back(v(1,1,0,0,4'h1,4'h0,1, 4'h0,0,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h1,4'h0,2, 4'h0,0,0,4'h0,0));
      // Empty-mask start, then clear coinciding with a fault set.
      vecs.push_back(v(1,0,0,0,4'h0,4'h0,2, 4'h0,0,0,4'h0,0));
      vecs.push_back(v(1,0,0,0,4'h1,4'h0,1, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h1,4'h0,3, 4'h1,1,0,4'h0,0));
      vecs.push_back(v(0,0,0,1,4'h1,4'h0,1, 4'h0,1,0,4'h1,0));
      vecs.push_back(v(0,0,0,0,4'h1,4'h0,1, 4'h0,1,0,4'h1,0));
      vecs.push_back(v(0,0,0,1,4'h1,4'h0,1, 4'h0,1,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h1,4'h0,4, 4'h0,0,1,4'h0,0));

      step(); step();
      rst_n = 1'b1;
      step();
      chk_all("reset", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);

      foreach (vecs[k]) begin
         start = vecs[k].start; stop = vecs[k].stop; cont = vecs[k].cont;
         clr = vecs[k].clr; ch_en = vecs[k].en; tie = vecs[k].tie;
         step();
         start = 1'b0; stop = 1'b0; clr = 1'b0;
         for (int c = 1; c < vecs[k].adv; c++) step();
         chk_all($sformatf("vec%0d", k), vecs[k].pulse, vecs[k].busy, vecs[k].done,
                 vecs[k].fault, vecs[k].cur);
      end

      // Synchronous reset in the gap with a fault pending on channel 2.
      tie = 4'h0; ch_en = 4'h4; cont = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("rst_seq pulse", 4'h4, 1'b1, 1'b0, 4'h0, 2'd2);
      repeat (4) step();
      chk_all("rst_seq fault", 4'h0, 1'b1, 1'b0, 4'h4, 2'd2);
      repeat (2) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_all("rst_seq cleared", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);
      repeat (12) step();
      chk_all("rst_seq idle", 4'h0, 1'b0, 1'b0, 4'h0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bk_test_sched

// File: doc/bk_test_sched.md
Name: bk_test_sched

Overview:
Multi-channel breakdown-test pulse scheduler on the 25 MHz domain. It time-multiplexes one test pulse per slot across up to CH_NUM channels in round-robin order. During each pulse it checks the channel's response input and latches a sticky per-channel fault when no response arrives. It sits between the box control logic (start/stop, channel mask) and the per-channel pulse drivers and feedback comparators.

Parameters:
CH_NUM, 4, number of test channels (2..16).
PULSE_CYC, 875, pulse high time in clocks (35 us at 25 MHz); must be >=1 and < SLOT_CYC.
SLOT_CYC, 250000, slot length in clocks, pulse start to next pulse start (10 ms).
CNT_W, 18, slot counter width; must hold SLOT_CYC-1.

Ports:
i_clk_25m  in  1  25 MHz clock, only clock.
i_rst_n  in  1  synchronous active-low reset.
i_start  in  1  start request, sampled in IDLE only.
i_stop  in  1  abort request, any state.
i_continuous  in  1  1 = repeat rounds until stop; 0 = single round.
i_ch_en  in  CH_NUM  channel enable mask, latched at each round start.
i_resp  in  CH_NUM  per-channel response/feedback, already synchronised.
i_fault_clr  in  1  clear all sticky faults.
o_bk_pulse  out  CH_NUM  test pulse outputs, at most one bit high.
o_cur_ch  out  $clog2(CH_NUM)  channel owning the current slot.
o_busy  out  1  high in PULSE or GAP.
o_round_done  out  1  one-cycle strobe at the end of each round.
o_fault  out  CH_NUM  sticky no-response flags.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): state IDLE, counter 0, latched mask 0. All outputs 0: o_bk_pulse, o_cur_ch, o_busy, o_round_done, o_fault.
- FSM states: IDLE, PULSE, GAP. All outputs are registered.
- IDLE: i_start=1 with i_ch_en!=0 at edge T:
  - latch the mask;
  - select the lowest enabled channel;
  - o_bk_pulse[ch]=1 and o_busy=1 from cycle T+1;
  - counter counts from 0.
  i_start with i_ch_en==0 is ignored and the block stays IDLE.
- PULSE: pulse is high for exactly PULSE_CYC cycles. A resp_seen flag is set if i_resp[ch]=1 in any of those cycles. Response on any other channel is ignored.
- PULSE->GAP after PULSE_CYC cycles. The pulse drops in the first GAP cycle. In that same cycle o_fault[ch] is set if resp_seen=0. resp_seen is cleared at each slot start.
- GAP lasts SLOT_CYC-PULSE_CYC cycles, so a slot is exactly SLOT_CYC cycles.
- GAP end, next channel: the next enabled channel above the current one in the latched mask, with no idle cycle.
- Wrap-around (no higher enabled channel):
  - o_round_done=1 for the first cycle of the following slot, or the first IDLE cycle;
  - if i_continuous=1: re-latch i_ch_en, pick its lowest enabled channel and start immediately;
  - if i_continuous=0, or the re-latched mask is 0: go to IDLE with o_busy=0.
- Pulse start of the k-th slot is at T+1+k*SLOT_CYC.
- i_stop=1 in any state: next cycle IDLE with pulse, o_busy and counter cleared. No fault update for the aborted slot and no o_round_done. i_stop takes priority over i_start in the same cycle.
- i_fault_clr clears o_fault next cycle. If it coincides with a fault set, the set wins for that channel.
- Mask changes mid-round have no effect until the next round latch.
- o_cur_ch holds the last channel value while IDLE.
- Counter arithmetic is unsigned CNT_W. Compares use PULSE_CYC-1 and SLOT_CYC-1, with no overflow beyond SLOT_CYC-1.

Decomposition:
- Shared package bk_pkg holds:
  - the state encoding typedef (IDLE/PULSE/GAP);
  - timing constants BK_PULSE_CYC=875 and BK_SLOT_CYC=250000 at 25 MHz, so the single-channel test generator and this block agree.
- One sub-module is natural: bk_rr_next. It is combinational: given the mask and the current channel, it returns the next channel and a wrap flag. It is reused by a future multi-box arbiter.

Test Plan (CH_NUM=4, PULSE_CYC=4, SLOT_CYC=10):
1. Mask 4'b1011, continuous=0, start at T, i_resp tied to o_bk_pulse:
   - ch0 high T+1..T+4, ch1 high T+11..T+14, ch3 high T+21..T+24;
   - o_round_done at T+31; o_busy falls at T+31; o_fault=0.
2. Mask 4'b0110, i_resp[2] held 0, all other responses tied to their pulses:
   - o_fault=4'b0100 set at T+15;
   - ch1 fault stays 0.
3. Continuous=1, mask 4'b0001:
   - ch0 pulse every 10 cycles;
   - o_round_done every 10 cycles;
   - mask changed to 4'b0010 mid-slot, so the next pulse is on ch1.
4. Stop at T+2 during the ch0 pulse, i_resp=0:
   - pulse low and o_busy=0 at T+3;
   - no o_fault, no o_round_done.
5. Start with mask 0: stays IDLE, all outputs 0. i_fault_clr asserted in the cycle a fault is set: the fault remains 1, and the next clr pulse clears it.
6. Reset asserted mid-GAP with o_fault!=0: next cycle all outputs 0 and state IDLE.
